// File: rtl/stream_max_finder.sv
`default_nettype none
// ============================================================================
// Module   : stream_max_finder
// Purpose  : Streaming argmax over a valid/ready sample frame (lowest index wins
//            ties). Optional min tracking: define STREAM_MAX_FINDER_MIN_EN.
// Revision : 1.0
// ============================================================================
module stream_max_finder #(
    parameter  int WIDTH      = 8,
    parameter  int NUM_INPUTS = 4,
    localparam int IDX_W      = $clog2(NUM_INPUTS),
    localparam int CNT_W      = $clog2(NUM_INPUTS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_value,
    output logic [IDX_W-1:0]        out_index,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_trunc
`ifdef STREAM_MAX_FINDER_MIN_EN
    ,
    output logic signed [WIDTH-1:0] out_min_value,
    output logic [IDX_W-1:0]        out_min_index
`endif
);

    localparam logic [CNT_W-1:0] c_LAST_POS = CNT_W'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic signed [WIDTH-1:0] r_best;
    logic [IDX_W-1:0]        r_best_idx;
    logic [CNT_W-1:0]        r_count;

    logic                    w_accept;
    logic [CNT_W-1:0]        w_pos;
    logic [CNT_W-1:0]        w_count;
    logic                    w_closing;
    logic                    w_take_new;
    logic signed [WIDTH-1:0] w_best;
    logic [IDX_W-1:0]        w_best_idx;

    assign in_ready   = (r_state != S_RESULT);
    assign w_accept   = in_valid && in_ready;
    // The first sample of a frame always sits at position 0, whatever r_count holds.
    assign w_pos      = (r_state == S_IDLE) ? '0 : r_count;
    assign w_count    = w_pos + CNT_W'(1);
    assign w_closing  = in_last || (w_pos == c_LAST_POS);
    assign w_take_new = (r_state == S_IDLE) || (in_data > r_best);
    assign w_best     = w_take_new ? in_data : r_best;
    assign w_best_idx = w_take_new ? w_pos[IDX_W-1:0] : r_best_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_closing ? S_RESULT : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_accept && w_closing) begin
                    w_next_state = S_RESULT;
                end
            end
            S_RESULT: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Running accumulators are separate from the result registers so the last
    // result stays visible while the next frame is being gathered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best     <= '0;
            r_best_idx <= '0;
            r_count    <= '0;
            out_valid  <= 1'b0;
            out_value  <= '0;
            out_index  <= '0;
            out_count  <= '0;
            out_trunc  <= 1'b0;
        end else begin
            out_valid <= (w_next_state == S_RESULT);
            if (w_accept) begin
                r_best     <= w_best;
                r_best_idx <= w_best_idx;
                r_count    <= w_count;
                if (w_closing) begin
                    out_value <= w_best;
                    out_index <= w_best_idx;
                    out_count <= w_count;
                    out_trunc <= !in_last;
                end
            end
        end
    end

`ifdef STREAM_MAX_FINDER_MIN_EN
    logic signed [WIDTH-1:0] r_min;
    logic [IDX_W-1:0]        r_min_idx;
    logic                    w_take_min;
    logic signed [WIDTH-1:0] w_min;
    logic [IDX_W-1:0]        w_min_idx;

    assign w_take_min = (r_state == S_IDLE) || (in_data < r_min);
    assign w_min      = w_take_min ? in_data : r_min;
    assign w_min_idx  = w_take_min ? w_pos[IDX_W-1:0] : r_min_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min         <= '0;
            r_min_idx     <= '0;
            out_min_value <= '0;
            out_min_index <= '0;
        end else if (w_accept) begin
            r_min     <= w_min;
            r_min_idx <= w_min_idx;
            if (w_closing) begin
                out_min_value <= w_min;
                out_min_index <= w_min_idx;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_max_finder.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_max_finder
// Purpose  : Self-checking bench for stream_max_finder (WIDTH=8, NUM_INPUTS=4).
// Revision : 1.0
// ============================================================================
module tb_stream_max_finder;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [7:0] out_value;
    logic [1:0]        out_index;
    logic [2:0]        out_count;
    logic              out_trunc;
    logic signed [7:0] out_min_value;
    logic [1:0]        out_min_index;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    stream_max_finder #(.WIDTH(8), .NUM_INPUTS(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_value     (out_value),
        .out_index     (out_index),
        .out_count     (out_count),
        .out_trunc     (out_trunc)
`ifdef STREAM_MAX_FINDER_MIN_EN
        ,
        .out_min_value (out_min_value),
        .out_min_index (out_min_index)
`endif
    );

`ifndef STREAM_MAX_FINDER_MIN_EN
    assign out_min_value = '0;
    assign out_min_index = '0;
`endif

    // Present one sample and hold it until accepted.
    task automatic push(input logic signed [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            n_total++;
            $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for a result, capture it, then take it.
    task automatic get_result(output logic ok, output logic signed [7:0] v,
                              output logic [1:0] idx, output logic [2:0] cnt,
                              output logic tr, output logic signed [7:0] mv,
                              output logic [1:0] mi);
        int n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ok  = (out_valid === 1'b1);
        v   = out_value;
        idx = out_index;
        cnt = out_count;
        tr  = out_trunc;
        mv  = out_min_value;
        mi  = out_min_index;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // Reference: maximum is found first, then the earliest position holding it.
    function automatic void model(input int q[$], output int mx, output int mxi,
                                  output int mn, output int mni);
        mx = q[0];
        mn = q[0];
        foreach (q[i]) begin
            if (q[i] > mx) mx = q[i];
            if (q[i] < mn) mn = q[i];
        end
        mxi = -1;
        mni = -1;
        foreach (q[i]) begin
            if (mxi < 0 && q[i] == mx) mxi = i;
            if (mni < 0 && q[i] == mn) mni = i;
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_total++;
        if ({in_ready, out_valid, out_value, out_index, out_count, out_trunc, out_min_value, out_min_index}
            !== {1'b1, 1'b0, 8'h00, 2'd0, 3'd0, 1'b0, 8'h00, 2'd0})
            $display("FAIL reset_state: rdy=%b vld=%b val=%0d idx=%0d cnt=%0d tr=%b required rdy=1 vld=0 rest 0",
                     in_ready, out_valid, out_value, out_index, out_count, out_trunc);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic ok, tr;
        logic signed [7:0] v, mv;
        logic [1:0] idx, mi;
        logic [2:0] cnt;
        push(8'sd3, 1'b0); push(-8'sd5, 1'b0); push(8'sd7, 1'b0);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL early_valid: out_valid=%b required 0", out_valid);
        else n_pass++;
        push(8'sd2, 1'b1);
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL latency: out_valid=%b required 1", out_valid);
        else n_pass++;
        get_result(ok, v, idx, cnt, tr, mv, mi);
        n_total++;
        if (!ok || {v, idx, cnt, tr} !== {8'sd7, 2'd2, 3'd4, 1'b0})
            $display("FAIL frame_basic: got %0d/%0d/%0d/%b required 7/2/4/0", v, idx, cnt, tr);
        else n_pass++;

        push(8'sd5, 1'b0); push(8'sd5, 1'b0); push(8'sd1, 1'b1);
        get_result(ok, v, idx, cnt, tr, mv, mi);
        n_total++;
        if (!ok || {v, idx, cnt, tr} !== {8'sd5, 2'd0, 3'd3, 1'b0})
            $display("FAIL frame_tie: got %0d/%0d/%0d/%b required 5/0/3/0", v, idx, cnt, tr);
        else n_pass++;

        push(-8'sd128, 1'b0); push(-8'sd1, 1'b1);
        get_result(ok, v, idx, cnt, tr, mv, mi);
        n_total++;
        if (!ok || {v, idx, cnt, tr} !== {8'hFF, 2'd1, 3'd2, 1'b0})
            $display("FAIL frame_neg: got %0d/%0d/%0d/%b required -1/1/2/0", v, idx, cnt, tr);
        else n_pass++;
`ifdef STREAM_MAX_FINDER_MIN_EN
        n_total++;
        if ({mv, mi} !== {8'h80, 2'd0})
            $display("FAIL frame_neg_min: got %0d/%0d required -128/0", mv, mi);
        else n_pass++;
`endif
    endtask

    task automatic test_trunc_backpressure();
        logic ok, tr;
        logic signed [7:0] v, mv;
        logic [1:0] idx, mi;
        logic [2:0] cnt;
        push(8'sd1, 1'b0); push(8'sd2, 1'b0); push(8'sd3, 1'b0); push(8'sd4, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'sd9;
        in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_total++;
            if ({in_ready, out_valid, out_value, out_index, out_count, out_trunc}
                !== {1'b0, 1'b1, 8'sd4, 2'd3, 3'd4, 1'b1})
                $display("FAIL hold_result[%0d]: rdy=%b vld=%b got %0d/%0d/%0d/%b required rdy=0 vld=1 4/3/4/1",
                         c, in_ready, out_valid, out_value, out_index, out_count, out_trunc);
            else n_pass++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_total++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL release: rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
        else n_pass++;
        push(8'sd9, 1'b0); push(8'sd9, 1'b1);
        get_result(ok, v, idx, cnt, tr, mv, mi);
        n_total++;
        if (!ok || {v, idx, cnt, tr} !== {8'sd9, 2'd0, 3'd2, 1'b0})
            $display("FAIL after_trunc: got %0d/%0d/%0d/%b required 9/0/2/0", v, idx, cnt, tr);
        else n_pass++;

        push(8'sd1, 1'b0); push(8'sd2, 1'b0); push(8'sd3, 1'b0); push(8'sd4, 1'b1);
        get_result(ok, v, idx, cnt, tr, mv, mi);
        n_total++;
        if (!ok || {v, idx, cnt, tr} !== {8'sd4, 2'd3, 3'd4, 1'b0})
            $display("FAIL last_at_limit: got %0d/%0d/%0d/%b required 4/3/4/0", v, idx, cnt, tr);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        push(8'sd10, 1'b0); push(8'sd20, 1'b1);
        n_total++;
        if ({out_valid, in_ready, out_value, out_index, out_count, out_trunc}
            !== {1'b1, 1'b0, 8'sd20, 2'd1, 3'd2, 1'b0})
            $display("FAIL early_ready_result: vld=%b rdy=%b got %0d/%0d/%0d/%b required vld=1 rdy=0 20/1/2/0",
                     out_valid, in_ready, out_value, out_index, out_count, out_trunc);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL early_ready_take: rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_midframe();
        logic ok, tr;
        logic signed [7:0] v, mv;
        logic [1:0] idx, mi;
        logic [2:0] cnt;
        push(8'sd42, 1'b1);
        get_result(ok, v, idx, cnt, tr, mv, mi);
        n_total++;
        if (!ok || {v, idx, cnt, tr} !== {8'sd42, 2'd0, 3'd1, 1'b0})
            $display("FAIL single: got %0d/%0d/%0d/%b required 42/0/1/0", v, idx, cnt, tr);
        else n_pass++;
        push(8'sd50, 1'b0); push(8'sd60, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({in_ready, out_valid, out_value, out_index, out_count, out_trunc, out_min_value, out_min_index}
            !== {1'b1, 1'b0, 8'h00, 2'd0, 3'd0, 1'b0, 8'h00, 2'd0})
            $display("FAIL async_reset: rdy=%b vld=%b val=%0d idx=%0d cnt=%0d tr=%b required rdy=1 vld=0 rest 0",
                     in_ready, out_valid, out_value, out_index, out_count, out_trunc);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        push(-8'sd3, 1'b0); push(-8'sd3, 1'b1);
        get_result(ok, v, idx, cnt, tr, mv, mi);
        n_total++;
        if (!ok || {v, idx, cnt, tr} !== {8'hFD, 2'd0, 3'd2, 1'b0})
            $display("FAIL post_reset: got %0d/%0d/%0d/%b required -3/0/2/0", v, idx, cnt, tr);
        else n_pass++;
    endtask

    task automatic test_random();
        int cur[$];
        int picks[4] = '{-128, 127, 0, 5};
        int mx, mxi, mn, mni;
        logic ok, tr, l;
        logic signed [7:0] v, mv, d;
        logic [1:0] idx, mi;
        logic [2:0] cnt;
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 3) == 0) d = 8'(picks[$urandom_range(0, 3)]);
            else d = 8'($urandom_range(0, 255));
            l = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
            push(d, l);
            cur.push_back(int'(d));
            if (l || cur.size() == 4) begin
                model(cur, mx, mxi, mn, mni);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                get_result(ok, v, idx, cnt, tr, mv, mi);
                n_total++;
                if (!ok || {v, idx, cnt, tr} !== {8'(mx), 2'(mxi), 3'(cur.size()), !l})
                    $display("FAIL random[%0d]: ok=%b got %0d/%0d/%0d/%b required %0d/%0d/%0d/%b",
                             k, ok, v, idx, cnt, tr, mx, mxi, cur.size(), !l);
                else n_pass++;
`ifdef STREAM_MAX_FINDER_MIN_EN
                n_total++;
                if ({mv, mi} !== {8'(mn), 2'(mni)})
                    $display("FAIL random_min[%0d]: got %0d/%0d required %0d/%0d", k, mv, mi, mn, mni);
                else n_pass++;
`endif
                cur.delete();
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_trunc_backpressure();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
